// File: rtl/vector_alu_status_control.sv
`default_nettype none
// ============================================================================
// vector_alu_status_control
// Sequences an element-wise signed vector ALU one element per clock and
// exposes busy/done/counter status alongside a registered result vector.
// Revision: 1.0 - initial release
// ============================================================================
module vector_alu_status_control #(
    parameter int DATA_WIDTH   = 16,
    parameter int VECTOR_DEPTH = 16,
    parameter int CNT_WIDTH    = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [CNT_WIDTH-1:0]               max_count,
    input  logic [1:0]                         op_type,
    input  logic [VECTOR_DEPTH*DATA_WIDTH-1:0] vec_a,
    input  logic [VECTOR_DEPTH*DATA_WIDTH-1:0] vec_b,
    output logic                               busy,
    output logic                               done,
    output logic [CNT_WIDTH-1:0]               counter,
    output logic [VECTOR_DEPTH*DATA_WIDTH-1:0] result
);

    localparam int IDX_W = (VECTOR_DEPTH > 1) ? $clog2(VECTOR_DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(VECTOR_DEPTH);
    localparam logic [CNT_WIDTH-1:0] ONE_C   = CNT_WIDTH'(1);

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_PASS = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   len_q, len_d;
    logic [1:0]             op_q, op_d;
    logic                   done_q, done_d;
    logic                   wr_en;

    logic [IDX_W-1:0]       idx;
    logic [DATA_WIDTH-1:0]  a_arr   [VECTOR_DEPTH];
    logic [DATA_WIDTH-1:0]  b_arr   [VECTOR_DEPTH];
    logic [DATA_WIDTH-1:0]  res_q   [VECTOR_DEPTH];
    logic [DATA_WIDTH-1:0]  a_sel;
    logic [DATA_WIDTH-1:0]  b_sel;
    logic [DATA_WIDTH-1:0]  alu_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            op_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            op_q    <= op_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        op_d    = op_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    len_d   = (max_count > DEPTH_C) ? DEPTH_C : max_count;
                    op_d    = op_type;
                end
            end
            ST_RUN: begin
                // An empty run still spends one RUN cycle before reporting done.
                if (len_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    wr_en = 1'b1;
                    if (cnt_q == len_q - ONE_C) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign idx = cnt_q[IDX_W-1:0];

    generate
        for (genvar i = 0; i < VECTOR_DEPTH; i++) begin : g_unpack
            assign a_arr[i] = vec_a[i*DATA_WIDTH +: DATA_WIDTH];
            assign b_arr[i] = vec_b[i*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign a_sel = a_arr[idx];
    assign b_sel = b_arr[idx];

    // The low half of a two's complement product does not depend on operand
    // signedness, so a same-width multiply yields the wrapped signed result.
    always_comb begin
        alu_out = a_sel;
        case (op_q)
            OP_ADD:  alu_out = a_sel + b_sel;
            OP_SUB:  alu_out = a_sel - b_sel;
            OP_MUL:  alu_out = a_sel * b_sel;
            OP_PASS: alu_out = a_sel;
            default: alu_out = a_sel;
        endcase
    end

    generate
        for (genvar i = 0; i < VECTOR_DEPTH; i++) begin : g_res
            localparam logic [IDX_W-1:0] IDX_C = IDX_W'(i);
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_q[i] <= '0;
                end else if (wr_en && (idx == IDX_C)) begin
                    res_q[i] <= alu_out;
                end
            end
            assign result[i*DATA_WIDTH +: DATA_WIDTH] = res_q[i];
        end
    endgenerate

    assign busy    = (state_q == ST_RUN);
    assign done    = done_q;
    assign counter = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_alu_status_control.sv
`default_nettype none
// ============================================================================
// tb_vector_alu_status_control
// Randomised and directed stimulus against a timing-formula reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vector_alu_status_control;

    localparam int DW = 16;
    localparam int VD = 16;
    localparam int CW = 5;
    localparam int RW = DW * VD;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic [CW-1:0] max_count = '0;
    logic [1:0]    op_type   = '0;
    logic [RW-1:0] vec_a     = '0;
    logic [RW-1:0] vec_b     = '0;
    logic          busy;
    logic          done;
    logic [CW-1:0] counter;
    logic [RW-1:0] result;

    always #5 clk = ~clk;

    vector_alu_status_control #(
        .DATA_WIDTH   (DW),
        .VECTOR_DEPTH (VD),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .max_count (max_count),
        .op_type   (op_type),
        .vec_a     (vec_a),
        .vec_b     (vec_b),
        .busy      (busy),
        .done      (done),
        .counter   (counter),
        .result    (result)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: a run accepted at edge t0 with N elements is busy in cycles
    // t0..t0+L-1 (L = max(N,1)), signals done in cycle t0+L, and writes
    // element k at edge t0+1+k.
    int            m_cyc;
    bit            m_act;
    int            m_t0;
    int            m_n;
    logic [1:0]    m_op;
    logic [DW-1:0] m_res [VD];

    function automatic int run_len(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    function automatic logic [DW-1:0] elem(input logic [RW-1:0] v, input int k);
        return v[k*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] alu_ref(input logic [1:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        int sa, sb, full;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            2'd0:    full = sa + sb;
            2'd1:    full = sa - sb;
            2'd2:    full = sa * sb;
            default: full = sa;
        endcase
        return full[DW-1:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc <= 0;
            m_act <= 1'b0;
            m_t0  <= 0;
            m_n   <= 0;
            m_op  <= '0;
            for (int k = 0; k < VD; k++) m_res[k] <= '0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_act && m_cyc >= m_t0 && (m_cyc - m_t0) < m_n)
                m_res[m_cyc-m_t0] <= alu_ref(m_op, elem(vec_a, m_cyc - m_t0),
                                             elem(vec_b, m_cyc - m_t0));
            if ((!m_act || m_cyc >= m_t0 + run_len(m_n)) && start) begin
                m_act <= 1'b1;
                m_t0  <= m_cyc + 1;
                m_n   <= (int'(max_count) > VD) ? VD : int'(max_count);
                m_op  <= op_type;
            end
        end
    end

    function automatic bit exp_busy();
        return m_act && m_cyc >= m_t0 && m_cyc < m_t0 + run_len(m_n);
    endfunction

    function automatic bit exp_done();
        return m_act && m_cyc == m_t0 + run_len(m_n);
    endfunction

    function automatic logic [CW-1:0] exp_cnt();
        return exp_busy() ? CW'(m_cyc - m_t0) : '0;
    endfunction

    function automatic logic [RW-1:0] exp_result();
        logic [RW-1:0] r;
        for (int k = 0; k < VD; k++) r[k*DW +: DW] = m_res[k];
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",    RW'(busy),    RW'(exp_busy()));
            chk("done",    RW'(done),    RW'(exp_done()));
            chk("counter", RW'(counter), RW'(exp_cnt()));
            chk("result",  result,       exp_result());
        end
    end

    // Issues a start from the current negedge and returns at the negedge of
    // the done cycle, so the caller may chain a back-to-back start.
    task automatic run(input int n, input logic [1:0] op, input bit poke);
        int l;
        l = run_len((n > VD) ? VD : n);
        max_count = CW'(n);
        op_type   = op;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        max_count = CW'($urandom);
        op_type   = 2'($urandom);
        for (int i = 0; i < l; i++) begin
            if (poke && l >= 5 && i == 2) start = 1'b1;
            if (poke && l >= 5 && i == 3) start = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic randomize_vectors();
        for (int k = 0; k < VD; k++) begin
            vec_a[k*DW +: DW] = DW'($urandom);
            vec_b[k*DW +: DW] = DW'($urandom);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", {busy, done, counter, result[RW-1-CW-2:0]}, '0);
        chk_en = 1'b1;
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_rst", {busy, done, counter, result[RW-1-CW-2:0]}, '0);

        for (int k = 0; k < VD; k++) begin
            vec_a[k*DW +: DW] = DW'(k);
            vec_b[k*DW +: DW] = 16'd100;
        end
        run(16, 2'd0, 1'b0);
        chk("add_done_cycle", RW'({busy, done}), RW'(2'b01));
        @(negedge clk);
        chk("add_e0",  RW'(result[0*DW +: DW]),  RW'(16'd100));
        chk("add_e7",  RW'(result[7*DW +: DW]),  RW'(16'd107));
        chk("add_e15", RW'(result[15*DW +: DW]), RW'(16'd115));

        randomize_vectors();
        run(4, 2'd3, 1'b0);
        @(negedge clk);
        chk("part_e0",  RW'(result[0*DW +: DW]),  RW'(vec_a[0*DW +: DW]));
        chk("part_e3",  RW'(result[3*DW +: DW]),  RW'(vec_a[3*DW +: DW]));
        chk("part_e4",  RW'(result[4*DW +: DW]),  RW'(16'd104));
        chk("part_e15", RW'(result[15*DW +: DW]), RW'(16'd115));

        vec_a[0 +: DW] = 16'h8000;
        vec_b[0 +: DW] = 16'h0001;
        run(1, 2'd1, 1'b0);
        @(negedge clk);
        chk("sub_wrap", RW'(result[0 +: DW]), RW'(16'h7FFF));

        vec_a[0 +: DW]  = 16'h0100;
        vec_b[0 +: DW]  = 16'h0100;
        vec_a[DW +: DW] = 16'hFFFD;
        vec_b[DW +: DW] = 16'h0007;
        run(2, 2'd2, 1'b0);
        @(negedge clk);
        chk("mul_wrap", RW'(result[0 +: DW]),  RW'(16'h0000));
        chk("mul_neg",  RW'(result[DW +: DW]), RW'(16'hFFEB));

        run(0, 2'd2, 1'b0);
        chk("n0_done", RW'({busy, done}), RW'(2'b01));
        @(negedge clk);

        randomize_vectors();
        run(8, 2'd0, 1'b1);
        run(5, 2'd1, 1'b0);
        @(negedge clk);

        randomize_vectors();
        run(20, 2'd2, 1'b0);
        @(negedge clk);

        repeat (40) begin
            randomize_vectors();
            run($urandom_range(0, 20), 2'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        @(negedge clk);

        randomize_vectors();
        max_count = CW'(16);
        op_type   = 2'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("cnt_before_rst", RW'(counter), RW'(7));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_run", {busy, done, counter, result[RW-1-CW-2:0]}, '0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        randomize_vectors();
        run(3, 2'd0, 1'b0);
        @(negedge clk);
        chk("after_rst_e3", RW'(result[3*DW +: DW]), RW'(16'd0));
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
